task_dispatcher: RTL

- Sits between the particle scheduler's task output and NUM_UNITS parallel kernel units (density/force evaluators).
- The scheduler issues one task per cycle with no backpressure, so this block buffers tasks in a FIFO.
- It hands each task to exactly one ready unit under round-robin arbitration.
- It signals when a frame's task stream has fully drained.

---
 rtl/sim_pkg.sv | 27 ++
 rtl/task_fifo.sv | 54 +++++
 rtl/task_dispatcher.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/sim_pkg.sv
// Shared particle-simulation types: task encoding and task field layout.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package sim_pkg;

  // Matches the scheduler's task_type encoding
  typedef enum logic [1:0] {
    DENSITY = 2'd0,
    FORCE   = 2'd1
  } task_type_t;

  // Fields packed into one task word, MSB first: {x_i, x_j, P_i, P_j, rho_j}
  localparam int TASK_FIELDS = 5;
  // Field k occupies bits [k*DATA_WIDTH +: DATA_WIDTH]
  localparam int FIELD_RHO_J = 0;
  localparam int FIELD_P_J   = 1;
  localparam int FIELD_P_I   = 2;
  localparam int FIELD_X_J   = 3;
  localparam int FIELD_X_I   = 4;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_ACTIVE   = 2'd1,
    ST_DRAINING = 2'd2
  } disp_state_t;

endpackage

// File: rtl/task_fifo.sv
// Generic synchronous FIFO with occupancy count; head word is always visible on rd_dat_o.
// Latency: a write is visible at the head one cycle later (no bypass).
// Backpressure: none upstream; a write to a full FIFO without a same-edge read is ignored.
module task_fifo #(
  parameter int WIDTH = 82,
  parameter int DEPTH = 8
) (
  input  logic                   clk_in,
  input  logic                   rst_in,
  input  logic                   wr_en_i,
  input  logic [WIDTH-1:0]       wr_dat_i,
  input  logic                   rd_en_i,
  output logic [WIDTH-1:0]       rd_dat_o,
  output logic [$clog2(DEPTH):0] count_o,
  output logic                   full_o,
  output logic                   empty_o
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [AW:0]      count_q;
  logic             do_wr;
  logic             do_rd;

  assign empty_o  = (count_q == '0);
  assign full_o   = (count_q == (AW+1)'(DEPTH));
  // A read frees a slot at the same edge, so a full FIFO can still accept a write
  assign do_rd    = rd_en_i & ~empty_o;
  assign do_wr    = wr_en_i & (~full_o | do_rd);
  assign rd_dat_o = mem_q[rd_ptr_q];
  assign count_o  = count_q;

  // Pointer and occupancy bookkeeping; pointers wrap naturally since DEPTH is a power of 2
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_wr) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_rd) rd_ptr_q <= rd_ptr_q + AW'(1);
      if (do_wr && !do_rd)      count_q <= count_q + (AW+1)'(1);
      else if (!do_wr && do_rd) count_q <= count_q - (AW+1)'(1);
    end
  end

  // Storage array; entries are don't-care until written
  always_ff @(posedge clk_in) begin
    if (do_wr) mem_q[wr_ptr_q] <= wr_dat_i;
  end

endmodule

// File: rtl/task_dispatcher.sv
// Buffers scheduler tasks and hands each to one ready kernel unit, round-robin; flags frame drain.
// Latency: task sampled at edge E0 is offered (unit_valid) in the cycle after E1.
// Backpressure: none upstream (drops when full, sticky overflow); offer held until some unit is ready.
module task_dispatcher
  import sim_pkg::*;
#(
  parameter int DATA_WIDTH  = 16,
  parameter int NUM_UNITS   = 4,
  parameter int FIFO_DEPTH  = 8,
  parameter int COUNT_WIDTH = 16
) (
  input  logic                              clk_in,
  input  logic                              rst_in,
  input  logic                              frame_start,
  input  logic                              sched_done,
  input  logic                              valid_task,
  input  logic [1:0]                        task_type,
  input  logic [DATA_WIDTH*TASK_FIELDS-1:0] task_data,
  input  logic [NUM_UNITS-1:0]              unit_ready,
  output logic [NUM_UNITS-1:0]              unit_valid,
  output logic [1:0]                        unit_task_type,
  output logic [DATA_WIDTH*TASK_FIELDS-1:0] unit_task_data,
  output logic [$clog2(FIFO_DEPTH):0]       fifo_count,
  output logic                              overflow,
  output logic [COUNT_WIDTH-1:0]            density_count,
  output logic [COUNT_WIDTH-1:0]            force_count,
  output logic                              drained
);
  localparam int TW = DATA_WIDTH * TASK_FIELDS;
  localparam int PW = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1;

  logic                   fifo_full;
  logic                   fifo_empty;
  logic [TW+1:0]          fifo_head;
  logic                   out_vld_q;
  logic [1:0]             out_type_q;
  logic [TW-1:0]          out_dat_q;
  logic [PW-1:0]          rr_ptr_q, rr_ptr_d;
  logic [NUM_UNITS-1:0]   grant;
  logic                   xfer;
  logic                   pop;
  logic                   drain_ok;
  logic                   ovf_q, ovf_d;
  logic [COUNT_WIDTH-1:0] den_q, den_d;
  logic [COUNT_WIDTH-1:0] frc_q, frc_d;
  disp_state_t            state_q, state_d;

  task_fifo #(
    .WIDTH (TW + 2),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_in   (clk_in),
    .rst_in   (rst_in),
    .wr_en_i  (valid_task),
    .wr_dat_i ({task_type, task_data}),
    .rd_en_i  (pop),
    .rd_dat_o (fifo_head),
    .count_o  (fifo_count),
    .full_o   (fifo_full),
    .empty_o  (fifo_empty)
  );

  // Round-robin grant: first ready unit at or above rr_ptr, wrapping; pointer moves only on a transfer
  always_comb begin
    logic          found;
    logic [PW-1:0] idx;
    grant    = '0;
    rr_ptr_d = rr_ptr_q;
    found    = 1'b0;
    idx      = '0;
    for (int i = 0; i < NUM_UNITS; i++) begin
      idx = PW'((int'(rr_ptr_q) + i) % NUM_UNITS);
      if (!found && unit_ready[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        rr_ptr_d   = PW'((int'(idx) + 1) % NUM_UNITS);
      end
    end
    if (!out_vld_q) rr_ptr_d = rr_ptr_q;
  end

  assign unit_valid     = out_vld_q ? grant : '0;
  assign xfer           = |unit_valid;
  // Refill the output stage whenever it is empty or being emptied this edge
  assign pop            = ~fifo_empty & (~out_vld_q | xfer);
  assign drain_ok       = fifo_empty & ~out_vld_q & ~valid_task;
  assign unit_task_type = out_type_q;
  assign unit_task_data = out_dat_q;
  assign overflow       = ovf_q;
  assign density_count  = den_q;
  assign force_count    = frc_q;

  // Per-frame counters and overflow flag; a transfer coinciding with frame_start counts as the new frame's first
  always_comb begin
    den_d = den_q;
    frc_d = frc_q;
    ovf_d = ovf_q;
    if (frame_start) begin
      den_d = '0;
      frc_d = '0;
      ovf_d = 1'b0;
    end
    if (xfer && out_type_q == DENSITY && den_d != '1) den_d = den_d + COUNT_WIDTH'(1);
    if (xfer && out_type_q == FORCE   && frc_d != '1) frc_d = frc_d + COUNT_WIDTH'(1);
    if (valid_task && fifo_full && !pop) ovf_d = 1'b1;
  end

  // Frame FSM: drained pulses on the DRAINING -> IDLE transition only
  always_comb begin
    state_d = state_q;
    drained = 1'b0;
    case (state_q)
      ST_IDLE:     if (frame_start) state_d = ST_ACTIVE;
      ST_ACTIVE:   if (!frame_start && sched_done) state_d = ST_DRAINING;
      ST_DRAINING: begin
        if (frame_start) begin
          state_d = ST_ACTIVE;
        end else if (drain_ok) begin
          state_d = ST_IDLE;
          drained = 1'b1;
        end
      end
      default:     state_d = ST_IDLE;
    endcase
  end

  // Output stage, arbitration pointer, counters and FSM state
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      out_vld_q  <= 1'b0;
      out_type_q <= '0;
      out_dat_q  <= '0;
      rr_ptr_q   <= '0;
      den_q      <= '0;
      frc_q      <= '0;
      ovf_q      <= 1'b0;
      state_q    <= ST_IDLE;
    end else begin
      if (pop) begin
        out_vld_q  <= 1'b1;
        out_type_q <= fifo_head[TW+1:TW];
        out_dat_q  <= fifo_head[TW-1:0];
      end else if (xfer) begin
        out_vld_q  <= 1'b0;
      end
      rr_ptr_q <= rr_ptr_d;
      den_q    <= den_d;
      frc_q    <= frc_d;
      ovf_q    <= ovf_d;
      state_q  <= state_d;
    end
  end

endmodule
